// File: rtl/fifo_uart_tx_pkg.sv
// Shared types for the FIFO-fed UART transmitter.
package fifo_uart_tx_pkg;

    // Frame sequencing states, 2-bit binary encoded.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/fifo_uart_tx.sv
// FIFO consumer that pops one word at a time and serializes it as a UART
// frame: one start bit, B data bits LSB first, one stop bit, each bit
// lasting CLKS_PER_BIT clocks. tx, busy and tx_done are registered; rd is
// the only combinational output.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int B            = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         empty,
    input  logic [B-1:0] r_data,
    output logic         rd,
    output logic         tx,
    output logic         busy,
    output logic         tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(B) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(B - 1);

    tx_state_e      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [B-1:0]   shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           busy_q, busy_d;
    logic           tx_done_q, tx_done_d;
    logic           bit_end;

    // Next-state logic for the frame sequencer, bit timer, bit index and shifter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        rd      = 1'b0;
        bit_end = (cnt_q == CNT_LAST);

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!empty && !reset) begin
                    rd      = 1'b1;
                    shift_d = r_data;
                    idx_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs are derived from the upcoming state so they line up with it.
    always_comb begin
        tx_d      = 1'b1;
        busy_d    = (state_d != ST_IDLE);
        tx_done_d = (state_d == ST_STOP) && (cnt_d == CNT_LAST);
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // State and output registers; reset forces the line idle and drops any word in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            tx_done_q <= tx_done_d;
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = tx_done_q;

endmodule
